// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry and
// legal port-count limits used by the elaboration-time parameter check.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_NUM_WR = 2;

    localparam int RD_MIN = 1;
    localparam int RD_MAX = 4;
    localparam int WR_MIN = 1;
    localparam int WR_MAX = 2;

    // True when the requested port counts fall inside the supported range.
    function automatic bit portsLegal(input int nRd, input int nWr);
        return (nRd >= RD_MIN) && (nRd <= RD_MAX) && (nWr >= WR_MIN) && (nWr <= WR_MAX);
    endfunction

endpackage

// File: rtl/reg_busy_sb.sv
// Register scoreboard: one busy bit per register. A producer issue sets the
// bit, a write to the register clears it, and a same-cycle set beats the
// clear. Read ports see the post-resolution value one cycle later.
module reg_busy_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           setEn,
    input  logic [ADDR_W-1:0]              setAddr,
    input  logic [NUM_WR-1:0]              clrEn,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  clrAddr,
    input  logic [NUM_RD-1:0]              rdEn,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rdAddr,
    output logic [NUM_RD-1:0]              rdBusy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;

    // Resolve this cycle's clears, then the set so a new producer wins.
    always_comb begin
        busyNext = busy;
        for (int k = 0; k < NUM_WR; k++) begin
            if (clrEn[k]) busyNext[clrAddr[k]] = 1'b0;
        end
        if (setEn) busyNext[setAddr] = 1'b1;
    end

    // Busy-bit storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= busyNext;
    end

    // Registered per-port busy lookup, bypassed through busyNext; holds when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdBusy <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (rdEn[p]) rdBusy[p] <= busyNext[rdAddr[p]];
            end
        end
    end

endmodule

// File: rtl/reg_file_mrnw.sv
// Multi-read / multi-write register file with write-through bypass, optional
// hard-wired zero register and an attached busy scoreboard. All outputs are
// registered; read latency is one cycle.
module reg_file_mrnw
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       sb_set_en,
    input  logic [ADDR_W-1:0]          sb_set_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    // Reject unsupported port counts while elaborating.
    if (!portsLegal(NUM_RD, NUM_WR)) begin : gBadParam
        $error("reg_file_mrnw: NUM_RD=%0d / NUM_WR=%0d outside supported range",
               NUM_RD, NUM_WR);
    end

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wrReq_t;

    wrReq_t [NUM_WR-1:0]             wrReq;
    logic   [NUM_WR-1:0]             wrEnEff;
    logic   [NUM_WR-1:0][ADDR_W-1:0] wrAddrV;
    logic   [NUM_RD-1:0][ADDR_W-1:0] rdAddrV;
    logic   [NUM_RD-1:0][DATA_W-1:0] rdQ;
    logic   [DEPTH-1:0][DATA_W-1:0]  mem;
    logic                            setEnEff;

    assign rdAddrV = rd_addr;
    assign rd_data = rdQ;

    // Writes aimed at a hard-wired zero register are dropped here, so neither
    // storage, bypass nor scoreboard clear ever sees them.
    for (genvar k = 0; k < NUM_WR; k++) begin : gWr
        logic [ADDR_W-1:0] a;
        assign a        = wr_addr[k*ADDR_W +: ADDR_W];
        assign wrReq[k] = '{en:   wr_en[k] && !(ZR && (a == '0)),
                            addr: a,
                            data: wr_data[k*DATA_W +: DATA_W]};
        assign wrEnEff[k] = wrReq[k].en;
        assign wrAddrV[k] = wrReq[k].addr;
    end

    assign setEnEff = sb_set_en && !(ZR && (sb_set_addr == '0));

    // Storage; ascending port order lets the higher index win a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wrReq[k].en) mem[wrReq[k].addr] <= wrReq[k].data;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : gRd
        logic [DATA_W-1:0] rdNext;

        // Array value, overridden by same-cycle writes (highest port last).
        always_comb begin
            rdNext = mem[rdAddrV[p]];
            for (int k = 0; k < NUM_WR; k++) begin
                if (wrReq[k].en && (wrReq[k].addr == rdAddrV[p])) rdNext = wrReq[k].data;
            end
            if (ZR && (rdAddrV[p] == '0)) rdNext = '0;
        end

        // Registered read data; holds while the port is idle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)          rdQ[p] <= '0;
            else if (rd_en[p]) rdQ[p] <= rdNext;
        end
    end

    // Register 0 can never become busy when hard-wired, so its busy reads are 0.
    reg_busy_sb #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) uSb (
        .clk     (clk),
        .rst     (rst),
        .setEn   (setEnEff),
        .setAddr (sb_set_addr),
        .clrEn   (wrEnEff),
        .clrAddr (wrAddrV),
        .rdEn    (rd_en),
        .rdAddr  (rdAddrV),
        .rdBusy  (rd_busy)
    );

endmodule

// File: tb/tb_reg_file_mrnw.sv
// Bench for reg_file_mrnw: one instance with a hard-wired zero register and
// one without, both driven by the same stimulus and compared each cycle
// against an array-based reference model.
module tb_reg_file_mrnw;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic              sb_set_en;
    logic [AW-1:0]     sb_set_addr;
    logic [NR*DW-1:0]  rdData0, rdData1;
    logic [NR-1:0]     rdBusy0, rdBusy1;

    reg_file_mrnw #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)) uDutZ (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdData0), .rd_busy(rdBusy0),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr));

    reg_file_mrnw #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(0)) uDutN (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdData1), .rd_busy(rdBusy1),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr));

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    // Reference state, index 0 = zero-register instance, 1 = plain instance.
    logic [31:0] mMem [2][32];
    bit          mBusy[2][32];
    logic [31:0] mRd  [2][NR];
    bit          mRdB [2][NR];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 32; a++) begin
                mMem[i][a]  = '0;
                mBusy[i][a] = 1'b0;
            end
            for (int p = 0; p < NR; p++) begin
                mRd[i][p]  = '0;
                mRdB[i][p] = 1'b0;
            end
        end
    endtask

    // Apply one rising edge worth of behaviour to the model.
    task automatic modelEdge();
        logic [4:0]  a, wa;
        logic [31:0] d;
        bit          b, z;
        for (int i = 0; i < 2; i++) begin
            z = (i == 0);
            for (int p = 0; p < NR; p++) begin
                if (rd_en[p]) begin
                    a = rd_addr[p*AW +: AW];
                    if (z && a == 0) begin
                        mRd[i][p]  = '0;
                        mRdB[i][p] = 1'b0;
                    end else begin
                        d = mMem[i][a];
                        b = mBusy[i][a];
                        for (int k = 0; k < NW; k++) begin
                            if (wr_en[k] && wr_addr[k*AW +: AW] == a) begin
                                d = wr_data[k*DW +: DW];
                                b = 1'b0;
                            end
                        end
                        if (sb_set_en && sb_set_addr == a) b = 1'b1;
                        mRd[i][p]  = d;
                        mRdB[i][p] = b;
                    end
                end
            end
            for (int k = 0; k < NW; k++) begin
                wa = wr_addr[k*AW +: AW];
                if (wr_en[k] && !(z && wa == 0)) begin
                    mMem[i][wa]  = wr_data[k*DW +: DW];
                    mBusy[i][wa] = 1'b0;
                end
            end
            if (sb_set_en && !(z && sb_set_addr == 0)) mBusy[i][sb_set_addr] = 1'b1;
        end
    endtask

    function automatic logic [31:0] gotData(input int i, input int p);
        return (i == 0) ? rdData0[p*DW +: DW] : rdData1[p*DW +: DW];
    endfunction

    function automatic logic gotBusy(input int i, input int p);
        return (i == 0) ? rdBusy0[p] : rdBusy1[p];
    endfunction

    task automatic checkAll(input string tag);
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < NR; p++) begin
                chk($sformatf("%s d%0d.%0d", tag, i, p), gotData(i, p), mRd[i][p]);
                chk($sformatf("%s b%0d.%0d", tag, i, p), {31'b0, gotBusy(i, p)}, {31'b0, mRdB[i][p]});
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rst) modelEdge();
        #1;
        checkAll(tag);
    endtask

    task automatic idle();
        wr_en = '0; rd_en = '0; sb_set_en = 1'b0;
    endtask

    task automatic setWr(input int k, input logic [4:0] a, input logic [31:0] d);
        wr_en[k] = 1'b1;
        wr_addr[k*AW +: AW] = a;
        wr_data[k*DW +: DW] = d;
    endtask

    task automatic setRd(input int p, input logic [4:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic doReset();
        rst = 1'b0;
        #1;
        modelClear();
        checkAll("rst");
    endtask

    initial begin
        rst = 1'b1; idle();
        wr_addr = '0; wr_data = '0; rd_addr = '0; sb_set_addr = '0;
        #1;
        doReset();
        // Activity during reset must be ignored.
        setWr(0, 5'd4, 32'h1234_5678); setRd(0, 5'd4); sb_set_en = 1'b1; sb_set_addr = 5'd4;
        step("inrst");
        step("inrst2");
        idle();
        rst = 1'b1;

        // All addresses read zero / not busy after reset.
        for (int a = 0; a < 32; a++) begin
            setRd(0, a[4:0]); setRd(1, a[4:0]);
            step("rstscan");
        end
        idle();

        // Write-through bypass on the other port.
        setWr(0, 5'd5, 32'hDEAD_BEEF); setRd(1, 5'd5);
        step("bypass");
        chk("bypass_const", rdData0[DW +: DW], 32'hDEAD_BEEF);
        idle();

        // Same-address collision: higher port wins.
        setWr(0, 5'd7, 32'h1111_1111); setWr(1, 5'd7, 32'h2222_2222);
        step("coll");
        idle(); setRd(0, 5'd7);
        step("collrd");
        chk("coll_const", rdData0[0 +: DW], 32'h2222_2222);
        idle();

        // Zero register with and without hard-wiring.
        setWr(0, 5'd0, 32'hFFFF_FFFF); setRd(0, 5'd0);
        step("x0");
        chk("x0_zr", rdData0[0 +: DW], 32'h0);
        chk("x0_nzr", rdData1[0 +: DW], 32'hFFFF_FFFF);
        idle();

        // Scoreboard set / clear / set-beats-clear.
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        step("sbset");
        idle(); setRd(0, 5'd9);
        step("sbrd");
        chk("sb_busy1", {31'b0, rdBusy0[0]}, 32'd1);
        idle(); setWr(1, 5'd9, 32'h5); setRd(0, 5'd9);
        step("sbclr");
        chk("sb_busy0", {31'b0, rdBusy0[0]}, 32'd0);
        idle(); setWr(0, 5'd9, 32'h6); sb_set_en = 1'b1; sb_set_addr = 5'd9; setRd(1, 5'd9);
        step("sbboth");
        chk("sb_win", {31'b0, rdBusy0[1]}, 32'd1);
        idle();

        // Reset between read issue and result discards the read and storage.
        setWr(0, 5'd3, 32'hA5A5_A5A5);
        step("x3wr");
        idle(); setRd(0, 5'd3);
        step("x3rd");
        chk("x3_val", rdData0[0 +: DW], 32'hA5A5_A5A5);
        #2;
        doReset();
        chk("x3_flush", rdData0[0 +: DW], 32'h0);
        step("x3rst");
        rst = 1'b1;
        step("x3after");
        chk("x3_lost", rdData0[0 +: DW], 32'h0);
        idle();

        // Randomized traffic, biased toward a few addresses to force collisions.
        for (int n = 0; n < 3000; n++) begin
            idle();
            for (int k = 0; k < NW; k++) begin
                wr_en[k] = ($urandom_range(0, 2) == 0);
                wr_addr[k*AW +: AW] = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                wr_data[k*DW +: DW] = $urandom;
            end
            for (int p = 0; p < NR; p++) begin
                rd_en[p] = ($urandom_range(0, 3) != 0);
                rd_addr[p*AW +: AW] = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            end
            sb_set_en   = ($urandom_range(0, 3) == 0);
            sb_set_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) begin
                doReset();
                step("rndrst");
                rst = 1'b1;
            end else begin
                step("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/reg_file_mrnw.md
REG_FILE_MRNW -- requirements
Module: reg_file_mrnw

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, read port count; legal range 1..4.
REQ-004 SHALL have parameter NUM_WR, default 2, write port count; legal range 1..2.
REQ-005 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port wr_en  input  NUM_WR  per-port write enable.
REQ-009 SHALL have port wr_addr  input  NUM_WR*ADDR_W  packed write indices, port k at slice k.
REQ-010 SHALL have port wr_data  input  NUM_WR*DATA_W  packed write data.
REQ-011 SHALL have port rd_en  input  NUM_RD  per-port read enable.
REQ-012 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read indices.
REQ-013 SHALL have port rd_data  output  NUM_RD*DATA_W  registered read data.
REQ-014 SHALL have port rd_busy  output  NUM_RD  registered scoreboard busy bit for each read address.
REQ-015 SHALL have port sb_set_en  input  1  mark register sb_set_addr busy (producer issued).
REQ-016 SHALL have port sb_set_addr  input  ADDR_W  register to mark busy.

Function
REQ-017 Read latency SHALL be one cycle: rd_data[p] after edge N reflects rd_addr[p] sampled at edge N.
REQ-018 When rd_en[p]=0, rd_data[p] and rd_busy[p] SHALL hold their previous values.
REQ-019 Write SHALL occur at the rising edge when wr_en[k]=1; new value readable from storage next cycle.
REQ-020 Read of an address written in the same cycle SHALL return the incoming wr_data (write-through bypass), not the stale array value.
REQ-021 Two write ports targeting the same address in one cycle: higher port index SHALL win for storage and bypass.
REQ-022 With ZERO_REG=1, reads of address 0 SHALL return 0 and rd_busy 0; writes and sb_set to address 0 SHALL be ignored, including bypass.
REQ-023 Scoreboard: one busy bit per register; sb_set_en sets the bit; any enabled write to that address clears it.
REQ-024 Simultaneous sb_set and write to the same address SHALL leave the bit set (new producer wins).
REQ-025 rd_busy[p] SHALL reflect the bit after same-cycle set/clear resolution (bypassed like data).
REQ-026 Out-of-range parameters SHALL be rejected at elaboration (generate-time error).
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 On rst low, all registers, busy bits, rd_data and rd_busy SHALL clear to 0 asynchronously.
REQ-029 Writes, reads and sb_set during reset SHALL have no effect; first effective edge is the first rising clk after rst deasserts.
REQ-030 Reset mid-operation SHALL discard any in-flight read result; outputs read 0 until next enabled read.

Structure
REQ-031 Shared package regfile_pkg SHALL hold the default DATA_W/ADDR_W/NUM_RD/NUM_WR constants and legal-range limits.
REQ-032 Scoreboard SHALL be a sub-module reg_busy_sb (set/clear ports, registered per-read-port busy output).
REQ-033 Storage and bypass muxing SHALL stay in reg_file_mrnw.

Verification
REQ-034 Reset then read all 32 addresses on both ports -> all rd_data 0, rd_busy 0.
REQ-035 Write x5=0xDEADBEEF via port 0 while reading x5 on port 1 same edge -> rd_data[1]=0xDEADBEEF next cycle.
REQ-036 Port 0 writes x7=0x11111111, port 1 writes x7=0x22222222 same edge -> later read x7 = 0x22222222.
REQ-037 Write x0=0xFFFFFFFF, read x0 with bypass -> 0; with ZERO_REG=0 -> 0xFFFFFFFF.
REQ-038 sb_set x9, read x9 -> busy 1; write x9=0x5 -> busy 0; set and write x9 same edge -> busy 1.
REQ-039 Drop rst between read issue and output -> rd_data 0, previous x3=0xA5A5A5A5 lost, later read x3 -> 0.
